// File: rtl/cpu_pkg.sv
// Shared constants for the Phase 3 CPU: opcodes, one-hot ALU operations and
// the control sequencer state encoding.
package cpu_pkg;

  // Instruction opcodes, ir[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // One-hot ALU operation selects
  localparam logic [11:0] ALU_NONE = 12'h000;
  localparam logic [11:0] ALU_ADD  = 12'h001;
  localparam logic [11:0] ALU_SUB  = 12'h002;
  localparam logic [11:0] ALU_AND  = 12'h100;
  localparam logic [11:0] ALU_OR   = 12'h200;

  // Sequencer states. Each opcode's execute states are declared in order so
  // that a non-final execute state simply advances to the next encoding.
  typedef enum logic [5:0] {
    S_RESET, S_T0, S_T1, S_T2, S_HALT,
    S_NOP_T3,
    ADD_T3,  ADD_T4,  ADD_T5,
    SUB_T3,  SUB_T4,  SUB_T5,
    AND_T3,  AND_T4,  AND_T5,
    OR_T3,   OR_T4,   OR_T5,
    ADDI_T3, ADDI_T4, ADDI_T5,
    ANDI_T3, ANDI_T4, ANDI_T5,
    ORI_T3,  ORI_T4,  ORI_T5,
    LDI_T3,  LDI_T4,  LDI_T5,
    LD_T3,   LD_T4,   LD_T5,  LD_T6,  LD_T7,
    ST_T3,   ST_T4,   ST_T5,  ST_T6,  ST_T7,
    BR_T3,   BR_T4,   BR_T5,  BR_T6,
    JR_T3,   MFHI_T3, MFLO_T3
  } state_t;

  // First state after fetch for a given opcode. Undefined opcodes and nop
  // spend one idle execute slot, giving them the same 4-cycle length as jr.
  function automatic state_t first_exec(input logic [4:0] op);
    state_t s;
    case (op)
      OP_LD:   s = LD_T3;
      OP_LDI:  s = LDI_T3;
      OP_ST:   s = ST_T3;
      OP_ADD:  s = ADD_T3;
      OP_SUB:  s = SUB_T3;
      OP_AND:  s = AND_T3;
      OP_OR:   s = OR_T3;
      OP_ADDI: s = ADDI_T3;
      OP_ANDI: s = ANDI_T3;
      OP_ORI:  s = ORI_T3;
      OP_BR:   s = BR_T3;
      OP_JR:   s = JR_T3;
      OP_MFHI: s = MFHI_T3;
      OP_MFLO: s = MFLO_T3;
      OP_HALT: s = S_HALT;
      default: s = S_NOP_T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer. One T-step per clock; every datapath
// strobe is decoded from the state register (br T6 additionally gates PCin
// with the CON FF, the only place that flag is looked at).
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        OutPortIn,
  output logic        MDRRead,
  output logic        RAMread,
  output logic        RAMwrite,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin_in,
  output logic        Rout_in,
  output logic        BAout,
  output logic        IncPC,
  output logic        con_FF_Reset,
  output logic [11:0] ALUControl,
  output logic        run,
  output logic [5:0]  state_o
);

  state_t state_q;
  state_t state_d;

  // Only the opcode field steers the sequencer; register fields go to the datapath.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  // Strobes not used by any instruction in this revision.
  assign Zhighout  = 1'b0;
  assign InPortout = 1'b0;
  assign HIin      = 1'b0;
  assign LOin      = 1'b0;
  assign OutPortIn = 1'b0;

  assign state_o = state_q;

  // Next-state: fetch chain, opcode dispatch after T2, final execute state back to T0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = first_exec(ir[31:27]);
      S_HALT:  state_d = S_HALT;
      S_NOP_T3, ADD_T5, SUB_T5, AND_T5, OR_T5, ADDI_T5, ANDI_T5, ORI_T5,
      LDI_T5, LD_T7, ST_T7, BR_T6, JR_T3, MFHI_T3, MFLO_T3:
               state_d = S_T0;
      default: state_d = state_t'(state_q + 6'd1);
    endcase
  end

  // State register; clr aborts any instruction immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // Output decode: each state lists only the strobes it raises.
  always_comb begin
    PCout        = 1'b0;
    MDRout       = 1'b0;
    Zlowout      = 1'b0;
    HIout        = 1'b0;
    LOout        = 1'b0;
    Cout         = 1'b0;
    PCin         = 1'b0;
    MARin        = 1'b0;
    MDRin        = 1'b0;
    IRin         = 1'b0;
    Yin          = 1'b0;
    Zin          = 1'b0;
    CONin        = 1'b0;
    MDRRead      = 1'b0;
    RAMread      = 1'b0;
    RAMwrite     = 1'b0;
    Gra          = 1'b0;
    Grb          = 1'b0;
    Grc          = 1'b0;
    Rin_in       = 1'b0;
    Rout_in      = 1'b0;
    BAout        = 1'b0;
    IncPC        = 1'b0;
    con_FF_Reset = 1'b0;
    ALUControl   = ALU_NONE;
    run          = (state_q != S_RESET) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; con_FF_Reset = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; MDRRead = 1'b1; MDRin = 1'b1; RAMread = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ADD_T3, SUB_T3, AND_T3, OR_T3, ADDI_T3, ANDI_T3, ORI_T3: begin
        Grb = 1'b1; Rout_in = 1'b1; Yin = 1'b1;
      end
      ADD_T4, SUB_T4, AND_T4, OR_T4: begin
        Grc = 1'b1; Rout_in = 1'b1; Zin = 1'b1;
      end
      ADDI_T4, ANDI_T4, ORI_T4, LDI_T4, LD_T4, ST_T4, BR_T5: begin
        Cout = 1'b1; Zin = 1'b1;
      end
      ADD_T5, SUB_T5, AND_T5, OR_T5, ADDI_T5, ANDI_T5, ORI_T5, LDI_T5: begin
        Zlowout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
      end
      LDI_T3, LD_T3, ST_T3: begin
        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
      end
      LD_T5, ST_T5: begin
        Zlowout = 1'b1; MARin = 1'b1;
      end
      LD_T6: begin
        MDRRead = 1'b1; MDRin = 1'b1; RAMread = 1'b1;
      end
      LD_T7: begin
        MDRout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
      end
      ST_T6: begin
        Gra = 1'b1; Rout_in = 1'b1; MDRin = 1'b1;
      end
      ST_T7: RAMwrite = 1'b1;
      BR_T3: begin
        Gra = 1'b1; Rout_in = 1'b1; CONin = 1'b1;
      end
      BR_T4: begin
        PCout = 1'b1; Yin = 1'b1;
      end
      BR_T6: begin
        Zlowout = 1'b1; PCin = con_ff;
      end
      JR_T3: begin
        Gra = 1'b1; Rout_in = 1'b1; PCin = 1'b1;
      end
      MFHI_T3: begin
        HIout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
      end
      MFLO_T3: begin
        LOout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
      end
      default: ;
    endcase
    case (state_q)
      ADD_T4, ADDI_T4, LDI_T4, LD_T4, ST_T4, BR_T5: ALUControl = ALU_ADD;
      SUB_T4:                                       ALUControl = ALU_SUB;
      AND_T4, ANDI_T4:                              ALUControl = ALU_AND;
      OR_T4, ORI_T4:                                ALUControl = ALU_OR;
      default:                                      ALUControl = ALU_NONE;
    endcase
  end

endmodule
